// File: rtl/bist_pkg.sv
// Shared types and default widths for the full-adder BIST sequencer.
package bist_pkg;

  localparam int SIG_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/bist_controller_if.sv
// Control/status bundle between the BIST sequencer and the TPG/MISR/CUT side.
// BIST_SIG_CAPTURE_EN adds the captured-signature return path.
interface bist_controller_if #(
  parameter int SIG_W = bist_pkg::SIG_W
);

  logic             start;
  logic             abort;
  logic [SIG_W-1:0] misr_sig;
  logic [SIG_W-1:0] golden_sig;
  logic             tpg_rst_n;
  logic             misr_rst_n;
  logic             test_mode;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0] sig_captured;
`endif

  // The sequencer drives clears/mode/status and consumes the run controls.
  modport master (
`ifdef BIST_SIG_CAPTURE_EN
    output sig_captured,
`endif
    input  start, abort, misr_sig, golden_sig,
    output tpg_rst_n, misr_rst_n, test_mode, busy, done, pass, fail
  );

  modport slave (
`ifdef BIST_SIG_CAPTURE_EN
    input  sig_captured,
`endif
    output start, abort, misr_sig, golden_sig,
    input  tpg_rst_n, misr_rst_n, test_mode, busy, done, pass, fail
  );

endinterface

// File: rtl/bist_controller.sv
// BIST sequencer: clear TPG/MISR, run PATTERN_COUNT patterns, settle, compare signature.
// Optional BIST_SIG_CAPTURE_EN keeps a copy of the compared MISR signature.
module bist_controller #(
  parameter int PATTERN_COUNT = 8,
  parameter int CNT_W         = bist_pkg::CNT_W,
  parameter int SIG_W         = bist_pkg::SIG_W
) (
  input  logic              clock,
  input  logic              reset,
  bist_controller_if.master bus
);

  import bist_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERN_COUNT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tpg_clr_n;
  logic             misr_clr_n;
  logic             test_mode_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic [SIG_W-1:0] sig_diff;
  logic             sig_match;
  logic             launch;

  assign sig_diff  = bus.misr_sig ^ bus.golden_sig;
  assign sig_match = ~|sig_diff;
  assign launch    = bus.start && (state == IDLE || state == DONE);

  // Outputs are registered from the next-state decision so none depend on inputs combinationally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tpg_clr_n   <= 1'b1;
      misr_clr_n  <= 1'b1;
      test_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (bus.abort) begin
      state       <= IDLE;
      cnt         <= '0;
      tpg_clr_n   <= 1'b1;
      misr_clr_n  <= 1'b1;
      test_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= INIT;
            cnt        <= '0;
            tpg_clr_n  <= 1'b0;
            misr_clr_n <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
          end
        end
        INIT: begin
          state       <= RUN;
          cnt         <= '0;
          tpg_clr_n   <= 1'b1;
          misr_clr_n  <= 1'b1;
          test_mode_q <= 1'b1;
        end
        RUN: begin
          // Exit on the last pattern instead of incrementing, so the counter never wraps.
          if (cnt == LAST_CNT) begin
            state       <= SETTLE;
            test_mode_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          state <= COMPARE;
        end
        COMPARE: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= sig_match;
          fail_q <= ~sig_match;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tpg_rst_n  = tpg_clr_n;
  assign bus.misr_rst_n = misr_clr_n;
  assign bus.test_mode  = test_mode_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;

`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0] sig_cap_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_cap_q <= '0;
    end else if (bus.abort || launch) begin
      sig_cap_q <= '0;
    end else if (state == COMPARE) begin
      sig_cap_q <= bus.misr_sig;
    end
  end

  assign bus.sig_captured = sig_cap_q;
`else
  logic unused_launch;
  assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: directed table, start/abort/reset corners, random runs.
module tb_bist_controller;

  localparam int PC = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  bist_controller_if #(.SIG_W(4)) bus ();

  bist_controller #(.PATTERN_COUNT(PC), .CNT_W(4), .SIG_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] golden;
    logic [3:0] misr;
    int         abort_at;
    int         ncyc;
    bit         exp_pass;
    bit         exp_fail;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] observed();
    logic [3:0] cap;
`ifdef BIST_SIG_CAPTURE_EN
    cap = bus.sig_captured;
`else
    cap = 4'h0;
`endif
    return {bus.tpg_rst_n, bus.misr_rst_n, bus.test_mode, bus.busy,
            bus.done, bus.pass, bus.fail, cap};
  endfunction

  // j = edges since the start-sampling edge: 0 is INIT, 1..PC run, then settle, compare, done.
  function automatic logic [10:0] model(int j, bit idle, logic [3:0] g, logic [3:0] m);
    bit clr_n, tm, bsy, dn, ps, fl;
    logic [3:0] cap;
    if (idle) return {1'b1, 1'b1, 9'b0};
    clr_n = (j != 0);
    tm    = (j >= 1) && (j <= PC);
    bsy   = (j <= PC + 2);
    dn    = (j >= PC + 3);
    ps    = dn && (g == m);
    fl    = dn && (g != m);
`ifdef BIST_SIG_CAPTURE_EN
    cap = dn ? m : 4'h0;
`else
    cap = 4'h0;
`endif
    return {clr_n, clr_n, tm, bsy, dn, ps, fl, cap};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b (tpg,misr,tm,busy,done,pass,fail,cap)", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run(input string name, input logic [3:0] g, input logic [3:0] m,
                     input int abort_at, input int ncyc);
    bit idle;
    idle = 1'b0;
    bus.golden_sig = g;
    bus.misr_sig   = m;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      if (abort_at != 0 && j >= abort_at) idle = 1'b1;
      chk($sformatf("%s j=%0d", name, j), observed(), model(j, idle, g, m));
      if (j == ncyc - 1) break;
      bus.abort = (j + 1 == abort_at);
      tick();
    end
    bus.abort = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.misr_sig   = 4'h0;
    bus.golden_sig = 4'h0;

    vecs[0] = '{4'hA, 4'hA, 0,  PC + 5, 1'b1, 1'b0};
    vecs[1] = '{4'hA, 4'h3, 0,  PC + 9, 1'b0, 1'b1};
    vecs[2] = '{4'hA, 4'hA, 5,  PC + 2, 1'b0, 1'b0};
    vecs[3] = '{4'h5, 4'h5, 1,  4,      1'b0, 1'b0};
    vecs[4] = '{4'hC, 4'hC, 12, PC + 6, 1'b0, 1'b0};
    vecs[5] = '{4'h0, 4'hF, 10, PC + 5, 1'b0, 1'b0};
    vecs[6] = '{4'hF, 4'hF, 0,  PC + 5, 1'b1, 1'b0};

    // Reset, then idle with start low.
    repeat (2) tick();
    chk("reset_held", observed(), model(0, 1'b1, 4'h0, 4'h0));
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_after_reset c=%0d", i), observed(), model(0, 1'b1, 4'h0, 4'h0));
    end

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      run($sformatf("vec%0d", v), vecs[v].golden, vecs[v].misr, vecs[v].abort_at, vecs[v].ncyc);
      chk_bit($sformatf("vec%0d pass", v), bus.pass, vecs[v].exp_pass);
      chk_bit($sformatf("vec%0d fail", v), bus.fail, vecs[v].exp_fail);
    end

    // start and abort on the same edge from IDLE: abort wins.
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    chk("start_abort_same_edge", observed(), model(0, 1'b1, 4'h0, 4'h0));
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("still_idle", observed(), model(0, 1'b1, 4'h0, 4'h0));

    // start held high: back-to-back runs, one DONE cycle between them.
    bus.golden_sig = 4'h6;
    bus.misr_sig   = 4'h6;
    bus.start      = 1'b1;
    for (int t = 0; t < 3 * (PC + 4); t++) begin
      tick();
      chk($sformatf("held_start t=%0d", t), observed(), model(t % (PC + 4), 1'b0, 4'h6, 4'h6));
    end
    bus.start = 1'b0;
    tick();
    chk("held_release_done", observed(), model(PC + 3, 1'b0, 4'h6, 4'h6));

    // Random runs against the timeline model.
    for (int r = 0; r < 25; r++) begin
      logic [3:0] g, m;
      int ab;
      g  = 4'($urandom_range(0, 15));
      m  = ($urandom_range(0, 1) == 1) ? g : 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PC + 4)) : 0;
      run($sformatf("rand%0d", r), g, m, ab, PC + 5);
    end

    // Asynchronous reset in the middle of RUN.
    run("pre_reset", 4'hA, 4'hA, 0, PC + 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("mid_run_before_reset", observed(), model(4, 1'b0, 4'hA, 4'hA));
    #2 reset = 1'b0;
    #1;
    chk("async_reset_immediate", observed(), model(0, 1'b1, 4'h0, 4'h0));
    tick();
    reset = 1'b1;
    tick();
    chk("after_reset_release", observed(), model(0, 1'b1, 4'h0, 4'h0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
